// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipe_stage_reg inter-stage register.
package pipe_pkg;

    localparam int DEF_DATA_W = 96;
    localparam int DEF_CNT_W  = 16;

    // A cleared stage presents an all-zero payload, which decodes as a NOP.
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_stall_cnt.sv
// Saturating event counter; holds at all-ones and clears only on reset.
module pipe_stall_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             cpu_clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge cpu_clk) begin
        if (reset)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable valid/ready pipeline stage with flush-to-bubble and stall counter.
// Define PIPE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_INSTR);

    logic accept;
    logic drain;

    // A flush cycle drops the upstream beat even when in_ready is high.
    assign accept = in_valid & in_ready & ~flush;
    assign drain  = out_valid & out_ready;

`ifdef PIPE_SKID_EN
    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              valid_q, in_ready_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !drain)      state_d = TWO;
                else if (drain && !accept) state_d = EMPTY;
            end
            TWO:   if (drain) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush)
            state_d = EMPTY;
    end

    // in_ready is a flop decoded from the next state, so out_ready never
    // reaches it combinationally.
    always_ff @(posedge cpu_clk) begin
        if (reset || flush) begin
            state_q    <= EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            valid_q    <= (state_d != EMPTY);
            in_ready_q <= (state_d != TWO);
            case (state_q)
                EMPTY: if (accept) main_q <= in_data;
                ONE: begin
                    if (accept && drain) main_q <= in_data;
                    else if (accept)     skid_q <= in_data;
                end
                TWO:   if (drain) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;
`else
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge cpu_clk) begin
        if (reset || flush) begin
            data_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else if (accept) begin
            data_q  <= in_data;
            valid_q <= 1'b1;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
`endif

    pipe_stall_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .inc     (out_valid & ~out_ready),
        .cnt     (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with an in-order scoreboard of accepted beats.
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CNT_W  = 4;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              cpu_clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    logic [DATA_W-1:0] sb[$];
    int                n_vec;
    int                n_err;
    bit                acc;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .cpu_clk   (cpu_clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes on the falling edge, then advance to just past the rising edge.
    task automatic tick();
        logic [DATA_W-1:0] exp;
        @(negedge cpu_clk);
        acc = in_valid && in_ready && !flush && !reset;
        if (out_valid && out_ready && !reset) begin
            exp = 'x;
            if (sb.size() > 0) exp = sb.pop_front();
            check("out_beat", out_data, exp);
        end
        if (reset || flush) sb.delete();
        else if (acc)       sb.push_back(in_data);
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] lst [3];
        int idx;
        int budget;
        int sent;

        n_vec = 0; n_err = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, i);
        end
        in_valid = 1'b0;
        tick();
        check("stream_idle", out_valid, 0);
        check("stream_drained", sb.size(), 0);
        check("stream_stall", stall_cnt, 0);

        // Backpressure with A, B, C.
        do_reset();
        lst[0] = 96'hA; lst[1] = 96'hB; lst[2] = 96'hC;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = (idx < 3);
            if (idx < 3) in_data = lst[idx];
            if (k == 1) check("bp_in_ready_second", in_ready, SKID ? 1 : 0);
            tick();
            if (acc) idx++;
        end
        check("bp_in_ready_full", in_ready, 0);
        check("bp_accepted", idx, SKID ? 2 : 1);
        check("bp_stall", stall_cnt, 5);
        check("bp_hold_data", out_data, 96'hA);
        out_ready = 1'b1;
        budget = 0;
        while ((idx < 3 || sb.size() > 0) && budget < 20) begin
            in_valid = (idx < 3);
            if (idx < 3) in_data = lst[idx];
            tick();
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        check("bp_all_sent", idx, 3);
        check("bp_drained", sb.size(), 0);
        check("bp_stall_after", stall_cnt, 5);

        // Flush while holding 0x5 (and 0x6 in the skid entry) with 0x7 offered.
        do_reset();
        in_valid = 1'b1; in_data = 96'h5;
        tick();
        in_data = 96'h6;
        tick();
        flush = 1'b1; in_data = 96'h7;
        tick();
        check("flush_out_valid", out_valid, 0);
        check("flush_out_data", out_data, 0);
        check("flush_keeps_stall", stall_cnt, 2);
        check("flush_in_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check("flush_no_beat", out_valid, 0);

        // Flush while the held beat drains: the transfer completes.
        in_valid = 1'b1; in_data = 96'h8;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_drain_valid", out_valid, 0);

        // Reset and flush together, with a beat stalled.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 96'h9;
        repeat (2) tick();
        in_valid = 1'b0; reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        check("rstflush_valid", out_valid, 0);
        check("rstflush_data", out_data, 0);
        check("rstflush_stall", stall_cnt, 0);

        // Reset in the middle of a transfer loses the beat.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 96'hE;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);

        // Stall counter saturation at 15.
        do_reset();
        in_valid = 1'b1; in_data = 96'hD;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("sat_mid", stall_cnt, 10);
        repeat (10) tick();
        check("sat_top", stall_cnt, 15);
        tick();
        check("sat_hold", stall_cnt, 15);
        check("sat_data_stable", out_data, 96'hD);
        out_ready = 1'b1;
        tick();
        check("sat_drain", out_valid, 0);

        // Toggle out_ready under a continuous stream.
        do_reset();
        sent = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h100;
        tick();
        if (acc) sent++;
        for (int k = 0; k < 12; k++) begin
            out_ready = k[0];
            in_data   = DATA_W'(32'h100 + sent);
            #1;
            if (!SKID) check("toggle_in_ready", in_ready, out_ready);
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            tick();
            budget++;
        end
        check("toggle_drained", sb.size(), 0);
        if (!SKID) check("toggle_sent", sent, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
